// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and
// data-memory wait/timeout handling for a classic 5-stage pipeline.
// Control outputs are Mealy (state plus current inputs, same-cycle effect).
// Optional feature macro: HAZARD_PERF_CNT_EN adds a saturating 16-bit stall
// counter on Stall_Count; without it Stall_Count is tied to zero.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal issue; load-use stalls handled in place
// MEM_WAIT | data memory busy, front end held and back end frozen
// FLUSH    | one cycle after a taken branch; load-use check suppressed
// ERROR    | memory timeout, pipeline frozen until reset

module pipeline_hazard_ctrl #(
   parameter int MAX_WAIT = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  ID_rs,
   input  logic [4:0]  ID_rt,
   input  logic        EX_MemRead,
   input  logic [4:0]  EX_rt,
   input  logic        Branch_Taken,
   input  logic        Mem_Busy,
   output logic        Block_PC_Write,
   output logic        Block_IF_ID_Write,
   output logic        Flush_IF_ID,
   output logic        Bubble_ID_EX,
   output logic        Freeze_Back,
   output logic        Mem_Timeout,
   output logic [15:0] Stall_Count
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      FLUSH    = 2'd2,
      ERROR    = 2'd3
   } state_t;

   localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

   state_t     state;
   state_t     state_nxt;
   logic [7:0] wait_cnt;
   logic [7:0] wait_cnt_nxt;
   logic       load_use;

   logic       blk_pc_raw;
   logic       blk_ifid_raw;
   logic       flush_raw;
   logic       bubble_raw;
   logic       freeze_raw;
   logic       timeout_raw;

   // Load in EX whose destination feeds the instruction currently in ID.
   assign load_use = EX_MemRead && (EX_rt != 5'd0) &&
                     ((EX_rt == ID_rs) || (EX_rt == ID_rt));

   // Next-state and raw control decode; priority is memory > branch > load-use.
   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      blk_pc_raw   = 1'b0;
      blk_ifid_raw = 1'b0;
      flush_raw    = 1'b0;
      bubble_raw   = 1'b0;
      freeze_raw   = 1'b0;
      timeout_raw  = 1'b0;
      case (state)
         RUN, FLUSH: begin
            state_nxt = RUN;
            if (Mem_Busy) begin
               blk_pc_raw   = 1'b1;
               blk_ifid_raw = 1'b1;
               freeze_raw   = 1'b1;
               state_nxt    = MEM_WAIT;
               wait_cnt_nxt = 8'd1;
            end else if (Branch_Taken) begin
               flush_raw  = 1'b1;
               bubble_raw = 1'b1;
               state_nxt  = FLUSH;
            end else if (load_use && (state == RUN)) begin
               blk_pc_raw   = 1'b1;
               blk_ifid_raw = 1'b1;
               bubble_raw   = 1'b1;
            end
         end
         MEM_WAIT: begin
            if (Mem_Busy) begin
               blk_pc_raw   = 1'b1;
               blk_ifid_raw = 1'b1;
               freeze_raw   = 1'b1;
               if (wait_cnt == MAX_WAIT_C) begin
                  state_nxt = ERROR;
               end else begin
                  wait_cnt_nxt = wait_cnt + 8'd1;
               end
            end else begin
               // Exit cycle: branch and load-use are deliberately ignored here.
               state_nxt    = RUN;
               wait_cnt_nxt = 8'd0;
            end
         end
         ERROR: begin
            blk_pc_raw   = 1'b1;
            blk_ifid_raw = 1'b1;
            freeze_raw   = 1'b1;
            timeout_raw  = 1'b1;
         end
         default: begin
            state_nxt    = RUN;
            wait_cnt_nxt = 8'd0;
         end
      endcase
   end

   // State and wait counter registers with asynchronous clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= RUN;
         wait_cnt <= 8'd0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
      end
   end

   // Outputs are forced low for as long as reset is held, independent of inputs.
   always_comb begin
      Block_PC_Write    = reset & blk_pc_raw;
      Block_IF_ID_Write = reset & blk_ifid_raw;
      Flush_IF_ID       = reset & flush_raw;
      Bubble_ID_EX      = reset & bubble_raw;
      Freeze_Back       = reset & freeze_raw;
      Mem_Timeout       = reset & timeout_raw;
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [15:0] stall_cnt;

   // Count every clock with the PC held, saturating at all-ones.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt <= 16'd0;
      end else if (Block_PC_Write && (stall_cnt != 16'hFFFF)) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end

   assign Stall_Count = stall_cnt;
`else
   assign Stall_Count = 16'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl. Two instances (MAX_WAIT 8 and 4)
// share stimulus; a cycle-level behavioural model checks both every cycle.
module tb_pipeline_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [4:0] ID_rs = '0, ID_rt = '0, EX_rt = '0;
   logic       EX_MemRead = 1'b0, Branch_Taken = 1'b0, Mem_Busy = 1'b0;

   logic [1:0]  pc, ifid, fl, bub, frz, tmo;
   logic [15:0] sc0, sc1;

   int n_chk = 0;
   int n_fail = 0;

   pipeline_hazard_ctrl #(.MAX_WAIT(8)) dut8 (
      .clk(clk), .reset(reset), .ID_rs(ID_rs), .ID_rt(ID_rt),
      .EX_MemRead(EX_MemRead), .EX_rt(EX_rt), .Branch_Taken(Branch_Taken),
      .Mem_Busy(Mem_Busy), .Block_PC_Write(pc[0]), .Block_IF_ID_Write(ifid[0]),
      .Flush_IF_ID(fl[0]), .Bubble_ID_EX(bub[0]), .Freeze_Back(frz[0]),
      .Mem_Timeout(tmo[0]), .Stall_Count(sc0));

   pipeline_hazard_ctrl #(.MAX_WAIT(4)) dut4 (
      .clk(clk), .reset(reset), .ID_rs(ID_rs), .ID_rt(ID_rt),
      .EX_MemRead(EX_MemRead), .EX_rt(EX_rt), .Branch_Taken(Branch_Taken),
      .Mem_Busy(Mem_Busy), .Block_PC_Write(pc[1]), .Block_IF_ID_Write(ifid[1]),
      .Flush_IF_ID(fl[1]), .Bubble_ID_EX(bub[1]), .Freeze_Back(frz[1]),
      .Mem_Timeout(tmo[1]), .Stall_Count(sc1));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: per instance, length of the current busy run, error latch, and
   // whether the previous cycle was a taken-branch flush.
   int m_run[2];
   bit m_err[2];
   bit m_fl[2];
   int m_stall[2];

   initial begin
      for (int d = 0; d < 2; d++) begin
         m_run[d] = 0; m_err[d] = 0; m_fl[d] = 0; m_stall[d] = 0;
      end
   end

   // Every-cycle comparison against the model, then advance the model.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         automatic int  mw = (d == 0) ? 8 : 4;
         automatic bit  lu = EX_MemRead && (EX_rt != 0) && (EX_rt == ID_rs || EX_rt == ID_rt);
         automatic bit  waiting = (m_run[d] > 0);
         automatic bit  e_pc = 0, e_if = 0, e_fl = 0, e_bub = 0, e_frz = 0, e_tmo = 0;
         automatic logic [15:0] act_sc = (d == 0) ? sc0 : sc1;
         if (!reset) begin
         end else if (m_err[d]) begin
            e_pc = 1; e_if = 1; e_frz = 1; e_tmo = 1;
         end else if (Mem_Busy) begin
            e_pc = 1; e_if = 1; e_frz = 1;
         end else if (waiting) begin
         end else if (Branch_Taken) begin
            e_fl = 1; e_bub = 1;
         end else if (lu && !m_fl[d]) begin
            e_pc = 1; e_if = 1; e_bub = 1;
         end
         check($sformatf("outs[pc,if,fl,bub,frz,tmo] mw%0d", mw),
               {10'd0, pc[d], ifid[d], fl[d], bub[d], frz[d], tmo[d]},
               {10'd0, e_pc, e_if, e_fl, e_bub, e_frz, e_tmo});
         check($sformatf("flush_vs_hold mw%0d", mw), {15'd0, fl[d] & ifid[d]}, 16'd0);
         check($sformatf("stall_count mw%0d", mw), act_sc, 16'(m_stall[d]));
         if (!reset) begin
            m_run[d] = 0; m_err[d] = 0; m_fl[d] = 0; m_stall[d] = 0;
         end else begin
`ifdef HAZARD_PERF_CNT_EN
            if (e_pc && m_stall[d] < 65535) m_stall[d]++;
`endif
            if (!m_err[d]) begin
               m_fl[d] = !Mem_Busy && !waiting && Branch_Taken;
               if (Mem_Busy) begin
                  m_run[d]++;
                  if (m_run[d] == mw + 1) m_err[d] = 1;
               end else begin
                  m_run[d] = 0;
               end
            end
         end
      end
   end

   task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic mr,
                        input logic [4:0] xrt, input logic br, input logic bz);
      @(posedge clk);
      #1;
      ID_rs = rs; ID_rt = rt; EX_MemRead = mr; EX_rt = xrt; Branch_Taken = br; Mem_Busy = bz;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0);
   endtask

   int cnt_pc;
   int cnt_frz;

   initial begin
      repeat (2) @(posedge clk);
      #2 reset = 1'b1;
      @(negedge clk);
      check("reset_state pc", {15'd0, pc[0]}, 16'd0);

      // load-use on rs, on rt, then the non-stall patterns
      drive(5, 0, 1, 5, 0, 0);
      @(negedge clk);
      check("lu_rs pc", {15'd0, pc[0]}, 16'd1);
      check("lu_rs bubble", {15'd0, bub[0]}, 16'd1);
      drive(0, 0, 1, 0, 0, 0);
      @(negedge clk);
      check("lu_r0 pc", {15'd0, pc[0]}, 16'd0);
      drive(3, 7, 1, 7, 0, 0);
      drive(3, 7, 0, 7, 0, 0);
      @(negedge clk);
      check("no_memread pc", {15'd0, pc[0]}, 16'd0);

      // taken branch, then load-use in FLUSH is ignored, then honoured in RUN
      drive(0, 0, 0, 0, 1, 0);
      @(negedge clk);
      check("branch flush", {15'd0, fl[0]}, 16'd1);
      check("branch hold", {15'd0, ifid[0]}, 16'd0);
      drive(5, 0, 1, 5, 0, 0);
      @(negedge clk);
      check("flush_lu pc", {15'd0, pc[0]}, 16'd0);
      drive(5, 0, 1, 5, 0, 0);
      @(negedge clk);
      check("run_lu pc", {15'd0, pc[0]}, 16'd1);
      drive(0, 0, 0, 0, 1, 0);
      drive(0, 0, 0, 0, 1, 0);
      @(negedge clk);
      check("branch_in_flush", {15'd0, fl[0]}, 16'd1);

      // three busy cycles, exit cycle carries branch + load-use that must be ignored
      cnt_pc = 0; cnt_frz = 0;
      for (int i = 0; i < 5; i++) begin
         if (i < 3) drive(0, 0, 0, 0, 0, 1);
         else if (i == 3) drive(5, 0, 1, 5, 1, 0);
         else idle();
         @(negedge clk);
         if (pc[0]) cnt_pc++;
         if (frz[0]) cnt_frz++;
      end
      check("busy3 pc cycles", 16'(cnt_pc), 16'd3);
      check("busy3 freeze cycles", 16'(cnt_frz), 16'd3);
      check("busy3 timeout", {14'd0, tmo}, 16'd0);

      // all three events together: memory wait wins
      drive(5, 0, 1, 5, 1, 1);
      @(negedge clk);
      check("combo pc", {15'd0, pc[0]}, 16'd1);
      check("combo flush", {15'd0, fl[0]}, 16'd0);
      check("combo bubble", {15'd0, bub[0]}, 16'd0);
      idle();

      // held busy: MAX_WAIT=4 instance times out, MAX_WAIT=8 does not
      for (int i = 0; i < 7; i++) drive(0, 0, 0, 0, 0, 1);
      idle();
      @(negedge clk);
      check("timeout mw4", {15'd0, tmo[1]}, 16'd1);
      check("timeout mw8", {15'd0, tmo[0]}, 16'd0);
      check("error hold mw4", {15'd0, pc[1]}, 16'd1);
      drive(5, 0, 1, 5, 1, 0);
      #1 reset = 1'b0;
      @(negedge clk);
      check("reset outs mw4", {10'd0, pc[1], ifid[1], fl[1], bub[1], frz[1], tmo[1]}, 16'd0);
      idle();
      #1 reset = 1'b1;
      @(negedge clk);
      check("after reset tmo", {15'd0, tmo[1]}, 16'd0);

      // reset asserted mid memory wait acts immediately
      drive(0, 0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 0, 1);
      #1 reset = 1'b0;
      @(negedge clk);
      check("mid_wait reset pc", {15'd0, pc[0]}, 16'd0);
      idle();
      #1 reset = 1'b1;

      // ten load-use stall cycles
      for (int i = 0; i < 10; i++) drive(0, 9, 1, 9, 0, 0);
      idle();
      @(negedge clk);
`ifdef HAZARD_PERF_CNT_EN
      check("stall_count 10", sc0, 16'd10);
`else
      check("stall_count off", sc0, 16'd0);
`endif
      repeat (2) idle();
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
